alu_arbiter: RTL

- Shares the single signed ALU datapath (5-bit signed operands, 3-bit opcode, 9-bit signed result, registered output) between two requesters.
- Each requester has a valid/ready request handshake and shares one valid/ready response channel.
- Arbitrates round-robin, issues one operation at a time, and waits out the ALU pipeline latency before returning the tagged result.
- Screens division by zero so it never reaches the ALU.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/rr_arb2.sv | 23 ++
 rtl/alu_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU widths, opcode and arbiter state types
// Contents: OPND_W/OPC_W/RES_W widths, opcode_t, arb_state_t, is_div_zero().
package alu_pkg;

   localparam int OPND_W = 5;
   localparam int OPC_W  = 3;
   localparam int RES_W  = 9;

   typedef enum logic [OPC_W-1:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_MUL  = 3'd2,
      OP_DIV  = 3'd3,
      OP_OR   = 3'd4,
      OP_AND  = 3'd5,
      OP_NAND = 3'd6,
      OP_NOR  = 3'd7
   } opcode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } arb_state_t;

   // Division by zero is answered locally and never issued to the ALU.
   function automatic logic is_div_zero(input logic [OPC_W-1:0]  op,
                                        input logic [OPND_W-1:0] in2);
      return (op == OP_DIV) && (in2 == '0);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter
// Ports: req[1:0] requests in; ptr current priority holder; advance = grant taken;
//        grant[1:0] one-hot or zero; ptr_next pointer after this cycle.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       ptr,
   input  logic       advance,
   output logic [1:0] grant,
   output logic       ptr_next
);

   // A lone requester always wins; the pointer only breaks ties.
   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = ptr ? 2'b10 : 2'b01;
      end
   end

   // After a grant, priority passes to the requester that lost (or was idle).
   assign ptr_next = advance ? ~grant[1] : ptr;

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one pipelined signed ALU between two requesters
// Ports: clk, rst (async, active-high);
//        req_valid/req_ready/req_in1/req_in2/req_op  per-requester request channel;
//        alu_in1/alu_in2/alu_opcode -> ALU, alu_out <- ALU;
//        rsp_valid/rsp_ready/rsp_id/rsp_data/rsp_err shared response channel;
//        op_count completed responses (wrapping).
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int ALU_LATENCY = 1,
   parameter int CNT_W       = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [1:0]                  req_valid,
   output logic [1:0]                  req_ready,
   input  logic [1:0][OPND_W-1:0]      req_in1,
   input  logic [1:0][OPND_W-1:0]      req_in2,
   input  logic [1:0][OPC_W-1:0]       req_op,
   output logic [OPND_W-1:0]           alu_in1,
   output logic [OPND_W-1:0]           alu_in2,
   output logic [OPC_W-1:0]            alu_opcode,
   input  logic [RES_W-1:0]            alu_out,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic                        rsp_id,
   output logic [RES_W-1:0]            rsp_data,
   output logic                        rsp_err,
   output logic [CNT_W-1:0]            op_count
);

   // Counter is loaded with ALU_LATENCY+1 (at most 8).
   localparam int LAT_W = 4;

   arb_state_t         state;
   logic               ptr;
   logic [LAT_W-1:0]   lat_cnt;
   logic [1:0]         grant;
   logic               ptr_next;
   logic               advance;
   logic               win_id;
   logic [OPND_W-1:0]  win_in1;
   logic [OPND_W-1:0]  win_in2;
   logic [OPC_W-1:0]   win_op;

   // Gated by rst so req_ready drops immediately while reset is held.
   assign advance   = (state == ST_IDLE) && !rst && (|req_valid);
   assign req_ready = advance ? grant : 2'b00;

   rr_arb2 u_rr_arb2 (
      .req      (req_valid),
      .ptr      (ptr),
      .advance  (advance),
      .grant    (grant),
      .ptr_next (ptr_next)
   );

   assign win_id  = grant[1];
   assign win_in1 = req_in1[win_id];
   assign win_in2 = req_in2[win_id];
   assign win_op  = req_op[win_id];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         ptr        <= 1'b0;
         lat_cnt    <= '0;
         alu_in1    <= '0;
         alu_in2    <= '0;
         alu_opcode <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_data   <= '0;
         rsp_err    <= 1'b0;
         op_count   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|req_valid) begin
                  ptr    <= ptr_next;
                  rsp_id <= win_id;
                  if (is_div_zero(win_op, win_in2)) begin
                     // Answered locally; ALU operands keep their previous values.
                     rsp_data  <= '0;
                     rsp_err   <= 1'b1;
                     rsp_valid <= 1'b1;
                     state     <= ST_RESP;
                  end else begin
                     alu_in1    <= win_in1;
                     alu_in2    <= win_in2;
                     alu_opcode <= win_op;
                     lat_cnt    <= LAT_W'(ALU_LATENCY + 1);
                     state      <= ST_EXEC;
                  end
               end
            end
            ST_EXEC: begin
               lat_cnt <= lat_cnt - LAT_W'(1);
               // One edge for the operand registers, ALU_LATENCY edges in the ALU.
               if (lat_cnt == LAT_W'(1)) begin
                  rsp_data  <= alu_out;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  op_count  <= op_count + CNT_W'(1);
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
